// File: rtl/seven_segment_arbiter_pkg.sv
// Shared types and sizes for the seven-segment display arbiter.
package seven_segment_arbiter_pkg;
  localparam int unsigned n_req  = 4;
  localparam int unsigned hold_w = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BLANK = 2'd2
  } state_t;
endpackage

// File: rtl/seven_segment_arbiter_rr_pick.sv
// Combinational round-robin finder: first set req bit at or after start, wrapping.
module rr_pick
  import seven_segment_arbiter_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] start,
  output logic       found,
  output logic [1:0] idx
);
  logic [1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = start;
    cand  = start;
    for (int unsigned k = 0; k < n_req; k++) begin
      cand = start + 2'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end
endmodule

// File: rtl/seven_segment_arbiter.sv
// Round-robin time-sharing of one seven-segment display among four number sources.
module seven_segment_arbiter
  import seven_segment_arbiter_pkg::*;
#(
  parameter int unsigned w    = 32,
  parameter int unsigned hold = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [3:0]       req,
  input  logic             lock,
  input  logic [4*w-1:0]   num_in,
  input  logic [31:0]      dots_in,
  output logic [w-1:0]     num,
  output logic [7:0]       dots,
  output logic [3:0]       grant,
  output logic [1:0]       owner,
  output logic [7:0]       switch_count
);
  localparam logic [hold_w-1:0] hold_last = hold_w'(hold - 1);

  state_t            state, state_n;
  logic [1:0]        owner_n;
  logic [hold_w-1:0] hold_cnt, hold_n;
  logic [7:0]        switch_n;
  logic              pick_found;
  logic [1:0]        pick_idx;
  logic [3:0]        others;

  // Search always begins just past the current/last owner.
  rr_pick u_pick (
    .req   (req),
    .start (owner + 2'd1),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign others = req & ~(4'b0001 << owner);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      owner        <= 2'd3;
      hold_cnt     <= '0;
      switch_count <= '0;
    end else begin
      state        <= state_n;
      owner        <= owner_n;
      hold_cnt     <= hold_n;
      switch_count <= switch_n;
    end
  end

  always_comb begin
    state_n  = state;
    owner_n  = owner;
    hold_n   = hold_cnt;
    switch_n = switch_count;
    unique case (state)
      IDLE: begin
        hold_n = '0;
        if (pick_found) begin
          state_n  = GRANT;
          owner_n  = pick_idx;
          switch_n = switch_count + 8'd1;
        end
      end
      GRANT: begin
        // Owner drop outranks both lock and the slot timer.
        if (!req[owner]) begin
          state_n = BLANK;
        end else if (en) begin
          if (hold_cnt == hold_last) begin
            hold_n = '0;
            if (!lock && (others != 4'b0000)) state_n = BLANK;
          end else begin
            hold_n = hold_cnt + 1'b1;
          end
        end
      end
      BLANK: begin
        if (en) begin
          if (pick_found) begin
            state_n  = GRANT;
            owner_n  = pick_idx;
            hold_n   = '0;
            switch_n = switch_count + 8'd1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    grant = '0;
    num   = '0;
    dots  = '0;
    if (state == GRANT) begin
      grant = 4'b0001 << owner;
      for (int unsigned i = 0; i < n_req; i++) begin
        if (owner == 2'(i)) begin
          num  = num_in[i*w +: w];
          dots = dots_in[i*8 +: 8];
        end
      end
    end
  end
endmodule

// File: tb/tb_seven_segment_arbiter.sv
// Scoreboard bench for seven_segment_arbiter against a slot-level reference model.
module tb_seven_segment_arbiter;
  localparam int W    = 32;
  localparam int HOLD = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b0;
  logic [3:0]     req = '0;
  logic           lock = 1'b0;
  logic [4*W-1:0] num_in = '0;
  logic [31:0]    dots_in = '0;
  logic [W-1:0]   num;
  logic [7:0]     dots;
  logic [3:0]     grant;
  logic [1:0]     owner;
  logic [7:0]     switch_count;

  seven_segment_arbiter #(.w(W), .hold(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .lock(lock),
    .num_in(num_in), .dots_in(dots_in), .num(num), .dots(dots),
    .grant(grant), .owner(owner), .switch_count(switch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   grant;
    logic [1:0]   owner;
    logic [7:0]   sw;
    logic [W-1:0] num;
    logic [7:0]   dots;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  // Reference model: display phase, who is shown, ticks left in the slot.
  localparam int DARK_IDLE = 0, SHOWN = 1, GAP = 2;
  int m_phase, m_owner, m_left, m_grants;

  function automatic int next_requester(logic [3:0] r, int from);
    for (int k = 1; k <= 4; k++)
      if (r[(from + k) % 4]) return (from + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = DARK_IDLE; m_owner = 3; m_left = HOLD; m_grants = 0;
  endtask

  task automatic model_start_slot(int who);
    m_phase = SHOWN; m_owner = who; m_left = HOLD; m_grants = (m_grants + 1) % 256;
  endtask

  task automatic model_advance();
    int nxt;
    nxt = next_requester(req, m_owner);
    if (m_phase == DARK_IDLE) begin
      if (nxt >= 0) model_start_slot(nxt);
    end else if (m_phase == SHOWN) begin
      if (!req[m_owner]) m_phase = GAP;
      else if (en) begin
        m_left--;
        if (m_left == 0) begin
          m_left = HOLD;
          if (!lock && ((req & ~(4'd1 << m_owner)) != 0)) m_phase = GAP;
        end
      end
    end else if (en) begin
      if (nxt >= 0) model_start_slot(nxt);
      else m_phase = DARK_IDLE;
    end
  endtask

  task automatic push_expected();
    exp_t e;
    e.owner = 2'(m_owner);
    e.sw    = 8'(m_grants);
    if (m_phase == SHOWN) begin
      e.grant = 4'd1 << m_owner;
      e.num   = num_in[m_owner*W +: W];
      e.dots  = dots_in[m_owner*8 +: 8];
    end else begin
      e.grant = '0; e.num = '0; e.dots = '0;
    end
    exp_q.push_back(e);
  endtask

  task automatic randomize_sources();
    for (int i = 0; i < 4; i++) num_in[i*W +: W] = $urandom;
    dots_in = $urandom;
  endtask

  task automatic step(input logic [3:0] r, input logic l, input logic e);
    @(posedge clk); #1;
    rst_n = 1'b1; req = r; lock = l; en = e;
    randomize_sources();
    push_expected();
    model_advance();
  endtask

  // Asserted mid-cycle so the asynchronous clear is visible before the next edge.
  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; req = '0; en = 1'b0; lock = 1'b0;
    model_reset();
    push_expected();
  endtask

  task automatic run(input logic [3:0] r, input logic l, input int n, input int period);
    for (int i = 0; i < n; i++) step(r, l, (i % period) == period - 1);
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("grant", 64'(grant), 64'(e.grant));
        check("owner", 64'(owner), 64'(e.owner));
        check("switch_count", 64'(switch_count), 64'(e.sw));
        check("num", 64'(num), 64'(e.num));
        check("dots", 64'(dots), 64'(e.dots));
      end
    end
  end

  initial begin : stimulus
    model_reset();
    do_reset();
    step(4'b0000, 0, 0);
    step(4'b0100, 0, 0);
    run(4'b0100, 0, 4, 2);
    // Two sources alternating with hold expiries.
    run(4'b0011, 0, 70, 2);
    // Owner 1 drops mid-slot with source 3 waiting.
    run(4'b1010, 0, 30, 2);
    run(4'b1000, 0, 10, 3);
    // Lock pins the owner across expiries, then release.
    run(4'b0011, 1, 100, 2);
    run(4'b0011, 0, 40, 2);
    // Sole requester drops and reasserts before the blank tick; then full release.
    run(4'b0100, 0, 6, 2);
    step(4'b0000, 0, 1);
    step(4'b0100, 0, 0);
    step(4'b0100, 0, 1);
    run(4'b0100, 0, 3, 4);
    step(4'b0000, 0, 0);
    step(4'b0000, 0, 1);
    run(4'b0000, 0, 3, 2);
    // Reset while a grant is active.
    run(4'b0010, 0, 3, 2);
    do_reset();
    step(4'b0000, 0, 0);
    // 260 grants to exercise switch_count wrap.
    for (int i = 0; i < 260; i++) begin
      step(4'b0001, 0, 0);
      step(4'b0000, 0, 0);
      step(4'b0001, 0, 1);
    end
    // Randomized traffic with occasional resets.
    begin
      logic [3:0] r;
      logic l;
      r = '0; l = 1'b0;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 7) == 0) r = 4'($urandom);
        if ($urandom_range(0, 15) == 0) l = 1'($urandom);
        if ($urandom_range(0, 599) == 0) do_reset();
        else step(r, l, $urandom_range(0, 2) == 0);
      end
    end
    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seven_segment_arbiter.md
# seven_segment_arbiter

Time-shares the single eight-digit seven-segment display between four number sources (shift-strobe counters, FSM output counters, rotary-encoder value, etc.). Sits between the per-source number/dot buses and `seven_segment`, replacing the static switch mux. Grants one requester at a time in round-robin order. Each grant lasts a minimum number of display-rate ticks, with a one-tick blank between owners to avoid ghosting.

## Interface
Parameters:
- `w`, 32: width of each number bus and of `num`.
- `hold`, 8: ticks of `en` per grant slot; legal range 1..255.

Ports:
- `clk`  in  1: system clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `en`  in  1: tick strobe, one clock wide, from `strobe_gen`.
- `req`  in  4: per-source display request, level-sensitive.
- `lock`  in  1: when 1, suppresses hold-expiry rotation.
- `num_in`  in  4*w: source numbers; source i is at `[i*w +: w]`.
- `dots_in`  in  32: source dots; source i is at `[i*8 +: 8]`.
- `num`  out  w: number to `seven_segment`.
- `dots`  out  8: dots to `seven_segment`.
- `grant`  out  4: one-hot current owner; all zero when no owner.
- `owner`  out  2: index of the current or last owner.
- `switch_count`  out  8: number of grants issued; wraps.

## Operation
- States:
  - IDLE: no owner.
  - GRANT: owner displayed.
  - BLANK: between owners, display dark.
- Round-robin pick: first i with `req[i]`=1, searching from `owner+1` mod 4 upward. This is the only selection rule.
- IDLE:
  - `grant`=0, `num`=0, `dots`=0.
  - Any `req` bit set → GRANT next clock, with pick as owner.
  - `hold_cnt` cleared; `switch_count` +1.
- GRANT:
  - `grant`=onehot(owner), `num`=`num_in[owner]`, `dots`=`dots_in[owner]`.
  - Outputs are a combinational mux on the registered owner.
  - `hold_cnt` increments on each `en`.
  - Expiry is `en` with `hold_cnt`==`hold`-1.
  - At expiry, `hold_cnt`←0. If `lock`=0 and some `req[j]`, j≠owner, is set → BLANK. Otherwise stay in GRANT.
  - `req[owner]`=0 on any clock → BLANK next clock, regardless of `lock` or `hold_cnt`.
- BLANK:
  - `grant`=0, `num`=0, `dots`=0; `owner` retained.
  - Waits for the next `en`. On that `en`:
    - If a pick exists → GRANT with the new owner, `hold_cnt`←0, `switch_count` +1.
    - If no `req` is set → IDLE.
  - The pick may return the old owner if it is the only requester.
- `switch_count` wraps 255→0.
- `hold_cnt` width is 8 bits.

## Timing
- Reset (async assert, sync deassert upstream): state IDLE, `owner`=3 (so the first pick starts at 0), `hold_cnt`=0, `switch_count`=0, `grant`=0, `num`=0, `dots`=0.
- Reset during GRANT or BLANK takes effect immediately, with no blank tick.
- Latency:
  - `req` sampled in IDLE at clock t → `grant` valid after edge t+1.
  - Owner drop at clock t → dark after edge t+1.
- Expiry with another requester pending → exactly one BLANK interval, from the expiry edge to the next `en` edge, then the new owner.
- `en` arriving in the same cycle as an owner drop is not counted as a BLANK tick. BLANK always waits for a later `en`.
- `lock` and `req` changing simultaneously: the owner-drop rule has priority over the `lock` hold.
- `num_in` changes while owned propagate combinationally in the same cycle.

## Structure
- Package `seven_segment_arbiter_pkg`:
  - State localparams: IDLE=2'd0, GRANT=2'd1, BLANK=2'd2.
  - `n_req`=4.
  - `hold_w`=8.
- Sub-module `rr_pick`: combinational round-robin finder.
  - Inputs: `req[3:0]`, `start[1:0]`.
  - Outputs: `found`, `idx[1:0]`.
  - Used for both the IDLE and BLANK decisions.
- Main block holds the FSM, `hold_cnt`, `owner`, `switch_count` and the output mux.

## Test plan
- Reset, then `req`=4'b0100 → next clock `grant`=4'b0100, `owner`=2, `num`=`num_in[2]`, `switch_count`=1.
- `req`=4'b0011, `hold`=8, `lock`=0 → owner 0 for 8 `en` ticks, then one dark BLANK tick, then owner 1; after 8 more ticks, blank, then owner 0. `switch_count` increments by 1 at each grant.
- Owner 1 drops `req` mid-slot at `hold_cnt`=3, with `req`=4'b1000 still set → dark next clock, owner 3 on the next `en`.
- `lock`=1, `req`=4'b0011, owner 0 → owner 0 kept across 5 expiries. Then `lock`=0 → switches to 1 at the next expiry.
- Sole requester 2 drops its `req` and reasserts it before the BLANK `en` → re-granted owner 2, `switch_count` +1. With `req`=0 at that `en` → IDLE, outputs 0.
- Assert `rst_n`=0 during GRANT → `grant`=0, `num`=0, `switch_count`=0 immediately. 256 grants from reset → `switch_count` wraps to 0.
